nibble_serial_sub: RTL and testbench
====================================

# nibble_serial_sub

Multi-cycle unsigned/two's-complement subtractor for the sum board datapath. It computes `a - b` four bits per clock as `a + ~b + 1`, carrying the inter-nibble carry in a register. It trades latency for a single 4-bit slice of logic and is the subtract-side companion to the board's lookahead adder. A start/busy/done handshake lets the board controller launch one operation at a time and collect the result and flags.

## Interface

Parameters:
- `WIDTH`, default 16: operand width in bits. Must be a multiple of 4 and at least 4.
- `NIB`: derived as `WIDTH/4`, the number of RUN cycles.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: request a subtraction. Accepted only in IDLE.
- `a`, in, `WIDTH`: minuend. Sampled on the accepting edge.
- `b`, in, `WIDTH`: subtrahend. Sampled on the accepting edge.
- `busy`, out, 1: high while in RUN.
- `done`, out, 1: one-cycle pulse when the result is valid.
- `diff`, out, `WIDTH`: `a - b` modulo 2^WIDTH.
- `borrow`, out, 1: 1 when `a < b` unsigned, i.e. the inverse of the final carry.
- `ovf`, out, 1: signed overflow.
- `zero`, out, 1: `diff == 0`.

## Operation

- States are IDLE, RUN and DONE.
- IDLE, `start` = 1:
  - latch `a` and `b` into operand registers;
  - set carry register to 1 and nibble index to 0;
  - go to RUN.
- RUN, each edge:
  - nibble `i` result = `a[4i+3:4i] + ~b[4i+3:4i] + carry`;
  - write the 4-bit sum into nibble `i` of the result register;
  - carry <= cout;
  - `i` <= `i+1`.
- Last RUN edge (`i == NIB-1`), registered together with the final nibble:
  - `diff` = full result;
  - `borrow` = ~cout;
  - `ovf` = (`a[MSB] != b[MSB]`) && (`diff[MSB] != a[MSB]`);
  - `zero` = (full result == 0), evaluated with the final nibble included;
  - `done` <= 1;
  - go to DONE.
- DONE: `done` <= 0 on the next edge and return to IDLE.
- `start` in RUN or DONE is ignored and is not queued.
- Input changes after acceptance do not affect the operation in flight.
- `diff`, `borrow`, `ovf` and `zero` hold their values until the next completion. Intermediate nibbles are kept in an internal register, so `diff` never shows partial results.
- Reset values: state IDLE; `busy`, `done`, `diff`, `borrow`, `ovf`, `zero`, carry, index and operand registers all 0.
- Reset asserted mid-operation aborts immediately. No `done` is produced and the outputs read 0.

## Timing

- If `start` is accepted at edge k:
  - `busy` is high from edge k to edge k+NIB;
  - `done` and the flags are valid from edge k+NIB, with `done` high for exactly one cycle;
  - the earliest next accept is edge k+NIB+2.
- Latency is NIB+1 edges from accept to IDLE. For WIDTH=16, `done` is visible 4 cycles after the accepting edge.
- Throughput is one operation per NIB+2 cycles.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Structure

- Shared header `sub_defs.vh` holds:
  - the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the nibble width constant 4.
- The single sub-module is `sub_nibble`:
  - combinational, computes `s = x + ~y + cin` and `cout` for 4 bits;
  - internally uses generate/propagate lookahead, consistent with the adder slices.
- The top level holds:
  - the FSM;
  - the nibble index counter (width clog2(NIB), minimum 1);
  - the carry register;
  - the operand, result and flag registers.

## Test plan

All scenarios use WIDTH=16.
- `a`=0x1234, `b`=0x0234, pulse `start` → 4 cycles later `done`=1 and `diff`=0x1000, `borrow`=0, `ovf`=0, `zero`=0; `busy` high exactly 4 cycles.
- `a`=0x0005, `b`=0x0007 → `diff`=0xFFFE, `borrow`=1, `ovf`=0, `zero`=0.
- `a`=0x8000, `b`=0x0001 → `diff`=0x7FFF, `ovf`=1, `borrow`=0. Also `a`=0x7FFF, `b`=0xFFFF → `diff`=0x8000, `ovf`=1, `borrow`=1.
- `a`=`b`=0xABCD → `diff`=0x0000, `zero`=1, `borrow`=0. Also `a`=`b`=0 → `zero`=1.
- Accept 0x00FF−0x0001, then hold `start`=1 with `a`=0xFFFF, `b`=0 during RUN and DONE → only one `done`, with `diff`=0x00FE. The second operation is accepted at the first IDLE cycle.
- Drive `rst_n`=0 on the second RUN cycle → all outputs 0 and no `done`. After release, 0x0010−0x0001 → `diff`=0x000F.

Source files
------------

// File: rtl/nibble_serial_sub_pkg.sv
// Shared definitions for the nibble-serial subtractor.
// State encodings and slice width.
package nibble_serial_sub_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_sub_nibble.sv
// One 4-bit subtract slice: s = x + ~y + cin.
// Carries use generate/propagate lookahead.
import nibble_serial_sub_pkg::*;

module sub_nibble (
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W-1:0] yn;
  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W:0]   c;

  // lookahead carries over the inverted subtrahend
  always_comb begin
    yn   = ~y;
    g    = x & yn;
    p    = x ^ yn;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[NIB_W-1:0];
    cout = c[NIB_W];
  end

endmodule

// File: rtl/nibble_serial_sub.sv
// Multi-cycle subtractor, one nibble per clock.
// start/busy/done handshake, registered flags.
import nibble_serial_sub_pkg::*;

module nibble_serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int MSB   = WIDTH - 1;

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NIB - 1);

  state_t state;
  state_t state_nxt;

  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_nxt;

  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] nib_s;
  logic             nib_c;
  logic             last;
  logic [IDX_W+1:0] base;

  sub_nibble u_nib (
    .x    (nib_a),
    .y    (nib_b),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_c)
  );

  // select current slice, merge its sum
  always_comb begin
    base    = {idx, 2'b00};
    nib_a   = a_q[base +: NIB_W];
    nib_b   = b_q[base +: NIB_W];
    last    = (idx == LAST);
    res_nxt = res_q;
    res_nxt[base +: NIB_W] = nib_s;
  end

  assign busy = (state == S_RUN);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // operand, carry, result and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            carry <= 1'b1;
            idx   <= '0;
          end
        end
        S_RUN: begin
          res_q <= res_nxt;
          carry <= nib_c;
          idx   <= idx + 1'b1;
          if (last) begin
            diff   <= res_nxt;
            borrow <= ~nib_c;
            ovf    <= (a_q[MSB] != b_q[MSB])
                   && (res_nxt[MSB] != a_q[MSB]);
            zero   <= (res_nxt == '0);
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Scoreboard bench for nibble_serial_sub.
// Driver queues expectations, monitor checks on done.
module tb_nibble_serial_sub;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         zero;

  int checks = 0;
  int failures = 0;
  int dones = 0;
  exp_t sb[$];
  logic done_prev = 1'b0;

  nibble_serial_sub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    exp_t e;
    int ux, uy, sx, sy, sd;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 32768) ? ux - 65536 : ux;
    sy = (uy >= 32768) ? uy - 65536 : uy;
    sd = sx - sy;
    e.diff   = W'((ux - uy + 65536) % 65536);
    e.borrow = (ux < uy);
    e.ovf    = (sd > 32767) || (sd < -32768);
    e.zero   = (ux == uy);
    return e;
  endfunction

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endtask

  // monitor: compare each completion to scoreboard
  always @(negedge clk) begin
    if (rst_n && done) begin
      dones++;
      chk("done_pulse_width", W'(done_prev), W'(0));
      chk("busy_at_done", W'(busy), W'(0));
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done diff=%h", diff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", diff, e.diff);
        chk("borrow", W'(borrow), W'(e.borrow));
        chk("ovf", W'(ovf), W'(e.ovf));
        chk("zero", W'(zero), W'(e.zero));
      end
    end
    done_prev = done;
  end

  // one op at full throughput, checking busy span
  task automatic run_op(input logic [W-1:0] x,
                        input logic [W-1:0] y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    for (int i = 0; i < 4; i++) begin
      chk("busy_high", W'(busy), W'(1));
      @(negedge clk);
    end
    chk("busy_low", W'(busy), W'(0));
  endtask

  initial begin
    logic [W-1:0] x, y;
    #1;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_diff", diff, W'(0));
    chk("rst_flags", W'({borrow, ovf, zero}), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0234);
    run_op(16'h0005, 16'h0007);
    run_op(16'h8000, 16'h0001);
    run_op(16'h7FFF, 16'hFFFF);
    run_op(16'hABCD, 16'hABCD);
    run_op(16'h0000, 16'h0000);

    // start held through RUN and DONE
    @(negedge clk);
    a = 16'h00FF;
    b = 16'h0001;
    start = 1'b1;
    sb.push_back(model(16'h00FF, 16'h0001));
    @(negedge clk);
    a = 16'hFFFF;
    b = 16'h0000;
    repeat (5) @(negedge clk);
    sb.push_back(model(16'hFFFF, 16'h0000));
    @(negedge clk);
    start = 1'b0;
    chk("second_accept", W'(busy), W'(1));
    repeat (5) @(negedge clk);
    chk("two_dones", W'(dones), W'(8));

    // reset on second RUN cycle aborts
    @(negedge clk);
    a = 16'h1234;
    b = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_diff", diff, W'(0));
    chk("abort_flags", W'({borrow, ovf, zero}), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_done", W'(dones), W'(8));
    run_op(16'h0010, 16'h0001);

    for (int n = 0; n < 40; n++) begin
      x = W'($urandom);
      y = (n % 7 == 0) ? x : W'($urandom);
      run_op(x, y);
    end

    repeat (8) @(negedge clk);
    chk("sb_empty", W'(sb.size()), W'(0));
    chk("done_count", W'(dones), W'(49));
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
